chan_sched: RTL and testbench

- Frame-level scheduler for the multi-channel ADPCM datapath.
- On each frame strobe it walks channels 0..NUM_CH-1 through the shared datapath. For each channel it:
  - reads that channel's state (delay registers) from state storage,
  - starts the datapath and waits for its done,
  - writes the updated state back.
- Sits between the frame timing logic and the shared codec datapath plus its per-channel state store.

---
 rtl/chan_sched_if.sv | 31 +++
 rtl/chan_sched.sv | 67 ++++++
 tb/tb_chan_sched.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/chan_sched_if.sv
// chan_sched_if: frame strobe, datapath handshake, state-store strobes and error flags of the channel scheduler
// Ports (scheduler view, modport master):
//   in : frame_sync, dp_done, clr_err
//   out: ch_sel, st_rd_en, dp_start, st_wr_en, busy, frame_done, err_overrun, err_timeout, err_ch
// modport slave is the mirror image, for the frame timing / datapath side.
interface chan_sched_if #(
    parameter int CH_W = 3
);
    logic            frame_sync;
    logic            dp_done;
    logic            clr_err;
    logic [CH_W-1:0] ch_sel;
    logic            st_rd_en;
    logic            dp_start;
    logic            st_wr_en;
    logic            busy;
    logic            frame_done;
    logic            err_overrun;
    logic            err_timeout;
    logic [CH_W-1:0] err_ch;
    modport master (
        input  frame_sync, dp_done, clr_err,
        output ch_sel, st_rd_en, dp_start, st_wr_en, busy, frame_done,
               err_overrun, err_timeout, err_ch
    );
    modport slave (
        output frame_sync, dp_done, clr_err,
        input  ch_sel, st_rd_en, dp_start, st_wr_en, busy, frame_done,
               err_overrun, err_timeout, err_ch
    );
endinterface

// File: rtl/chan_sched.sv
// chan_sched: per-frame walk of channels 0..NUM_CH-1 through the shared ADPCM datapath (load state, run, store state)
// Ports: clk, reset (sync, active-high), bus (chan_sched_if.master: frame/datapath handshake, store strobes, error flags)
module chan_sched #(
    parameter int NUM_CH  = 8,
    parameter int CH_W    = 3,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input logic          clk,
    input logic          reset,
    chan_sched_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, STORE, DONE} state_t;
    state_t          state, state_n;
    logic [TO_W-1:0] timer;
    logic            abort;
    logic [CH_W-1:0] ch_sel;
    logic [CH_W-1:0] err_ch;
    logic            err_overrun;
    logic            err_timeout;
    logic            to_hit;
    logic            last;
    // dp_done on the timeout cycle wins, so the abort needs dp_done low
    assign to_hit = state == WAIT && !bus.dp_done && timer == TO_W'(TIMEOUT - 1);
    assign last   = ch_sel == CH_W'(NUM_CH - 1);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.frame_sync ? LOAD : IDLE;
            LOAD:    state_n = START;
            START:   state_n = WAIT;
            WAIT:    state_n = (bus.dp_done || to_hit) ? STORE : WAIT;
            STORE:   state_n = last ? DONE : LOAD;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            abort       <= 1'b0;
            ch_sel      <= '0;
            err_ch      <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= state == START ? '0 : state == WAIT ? timer + 1'b1 : timer;
            abort       <= state == WAIT ? to_hit : abort;
            ch_sel      <= (state == STORE && !last) ? ch_sel + 1'b1 : (state == DONE || state == IDLE) ? '0 : ch_sel;
            // error events take priority over clr_err
            err_overrun <= (bus.frame_sync && state != IDLE) || (err_overrun && !bus.clr_err);
            err_timeout <= to_hit || (err_timeout && !bus.clr_err);
            err_ch      <= to_hit ? ch_sel : bus.clr_err ? '0 : err_ch;
        end
    end
    assign bus.ch_sel      = ch_sel;
    assign bus.st_rd_en    = state == LOAD;
    assign bus.dp_start    = state == START;
    assign bus.st_wr_en    = state == STORE && !abort;
    assign bus.busy        = state != IDLE;
    assign bus.frame_done  = state == DONE;
    assign bus.err_overrun = err_overrun;
    assign bus.err_timeout = err_timeout;
    assign bus.err_ch      = err_ch;
endmodule

// File: tb/tb_chan_sched.sv
// tb_chan_sched: scoreboard bench for chan_sched; expected strobe events are queued per frame and popped by a monitor
module tb_chan_sched;
    typedef struct {
        int kind;
        int ch;
        int rel;
    } ev_t;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   base = 0;
    int   total = 0;
    int   bad = 0;
    int   busy_cnt = 0;
    int   done_seen = 0;
    int   done_rel = 0;
    int   ext[8];
    int   cnt = 0;
    ev_t  exp_q[$];
    chan_sched_if #(.CH_W(3)) bus ();
    chan_sched #(.NUM_CH(8), .CH_W(3), .TIMEOUT(64), .TO_W(7)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc - base);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // Datapath model: dp_done comes ext[ch]+1 cycles after dp_start; ext<0 withholds it
    always @(posedge clk) begin
        #1;
        bus.dp_done = 1'b0;
        if (reset) cnt = 0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) bus.dp_done = 1'b1;
        end
        if (bus.dp_start && ext[bus.ch_sel] >= 0) cnt = ext[bus.ch_sel] + 1;
    end
    function automatic void push_ev(input int kind, input int ch, input int rel);
        ev_t e;
        e.kind = kind;
        e.ch   = ch;
        e.rel  = rel;
        exp_q.push_back(e);
    endfunction
    // Expected events: 0=st_rd_en 1=dp_start 2=st_wr_en 3=frame_done; cut = channel where reset will strike
    task automatic push_frame(input int cut);
        int t;
        int w;
        t = 1;
        for (int k = 0; k < 8; k++) begin
            push_ev(0, k, t);
            push_ev(1, k, t + 1);
            if (k == cut) return;
            w = ext[k] < 0 ? 64 : ext[k] + 1;
            if (ext[k] >= 0) push_ev(2, k, t + 2 + w);
            t += 3 + w;
        end
        push_ev(3, -1, t);
    endtask
    task automatic frame(input int cut);
        push_frame(cut);
        base = cyc;
        busy_cnt = 0;
        done_seen = 0;
        bus.frame_sync = 1'b1;
        step();
        bus.frame_sync = 1'b0;
    endtask
    task automatic wait_done(input string nm, input int req);
        int n;
        n = 0;
        while (!done_seen && n < 400) begin
            step();
            n++;
        end
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL %s actual=no_frame_done required=%0d", nm, req);
        end else check(nm, done_rel, req);
        step();
        step();
        check({nm, "_q_empty"}, exp_q.size(), 0);
    endtask
    task automatic set_ext(input int ch, input int v);
        for (int k = 0; k < 8; k++) ext[k] = 0;
        if (ch >= 0) ext[ch] = v;
    endtask
    always @(negedge clk) begin
        int  k;
        ev_t e;
        if (!reset) begin
            k = bus.st_rd_en ? 0 : bus.dp_start ? 1 : bus.st_wr_en ? 2 : bus.frame_done ? 3 : -1;
            if (bus.busy) busy_cnt++;
            if (bus.frame_done) begin
                done_seen = 1;
                done_rel  = cyc - base;
            end
            if (bus.ch_sel > 3'd7 || bus.err_ch > 3'd7) check("ch_range", 32'(bus.ch_sel), 7);
            if (k >= 0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe actual=kind%0d_ch%0d_rel%0d required=none", k, bus.ch_sel, cyc - base);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_kind", k, e.kind);
                    if (e.ch >= 0) check("ev_ch", 32'(bus.ch_sel), e.ch);
                    check("ev_rel", cyc - base, e.rel);
                end
            end
        end
    end
    initial begin
        set_ext(-1, 0);
        reset = 1'b1;
        bus.frame_sync = 1'b0;
        bus.clr_err = 1'b0;
        step();
        step();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_ch_sel", 32'(bus.ch_sel), 0);
        check("rst_strobes", 32'({bus.st_rd_en, bus.dp_start, bus.st_wr_en, bus.frame_done}), 0);
        check("rst_flags", 32'({bus.err_overrun, bus.err_timeout, bus.err_ch}), 0);
        reset = 1'b0;
        step();
        frame(-1);
        wait_done("clean_done", 33);
        check("clean_busy_cycles", busy_cnt, 33);
        check("clean_flags", 32'({bus.err_overrun, bus.err_timeout}), 0);
        set_ext(3, 10);
        frame(-1);
        wait_done("slow_ch3_done", 43);
        check("slow_flags", 32'({bus.err_overrun, bus.err_timeout}), 0);
        set_ext(5, -1);
        frame(-1);
        wait_done("timeout_ch5_done", 96);
        check("timeout_flag", 32'(bus.err_timeout), 1);
        check("timeout_err_ch", 32'(bus.err_ch), 5);
        check("timeout_no_overrun", 32'(bus.err_overrun), 0);
        set_ext(-1, 0);
        frame(-1);
        while (cyc < base + 10) step();
        bus.frame_sync = 1'b1;
        step();
        bus.frame_sync = 1'b0;
        check("overrun_busy", 32'(bus.busy), 1);
        wait_done("overrun_done", 33);
        repeat (8) step();
        check("overrun_flag", 32'(bus.err_overrun), 1);
        check("overrun_idle", 32'(bus.busy), 0);
        check("overrun_no_second_frame", exp_q.size(), 0);
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        check("clr_flags", 32'({bus.err_overrun, bus.err_timeout, bus.err_ch}), 0);
        set_ext(2, -1);
        frame(-1);
        while (cyc < base + 74) step();
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        check("clr_vs_to_flag", 32'(bus.err_timeout), 1);
        check("clr_vs_to_err_ch", 32'(bus.err_ch), 2);
        wait_done("to_ch2_done", 96);
        set_ext(4, -1);
        frame(4);
        while (cyc < base + 25) step();
        reset = 1'b1;
        step();
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_ch_sel", 32'(bus.ch_sel), 0);
        check("midrst_wr", 32'(bus.st_wr_en), 0);
        check("midrst_flags", 32'({bus.err_overrun, bus.err_timeout, bus.err_ch}), 0);
        reset = 1'b0;
        check("midrst_q_empty", exp_q.size(), 0);
        repeat (3) step();
        set_ext(-1, 0);
        frame(-1);
        wait_done("post_rst_done", 33);
        check("post_rst_busy_cycles", busy_cnt, 33);
        check("post_rst_flags", 32'({bus.err_overrun, bus.err_timeout}), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
